// File: rtl/icache_refill_pkg.sv
// Shared constants and state encoding for the icache miss/refill engine.
package icache_refill_pkg;

  localparam logic [2:0] RD_TYPE_WORD     = 3'b010;
  localparam logic [2:0] RD_TYPE_LINE     = 3'b100;
  localparam int         LINE_OFFSET_BITS = 4;
  localparam int         WORD_W           = 32;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_REQ  = 4'b0010,
    ST_RECV = 4'b0100,
    ST_DONE = 4'b1000
  } state_t;

endpackage

// File: rtl/icache_line_assembler.sv
// Beat counter, per-word write decode, line register and critical-word match.
module icache_line_assembler
  import icache_refill_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int CNT_W      = $clog2(LINE_WORDS)
) (
  input  logic                         aclk,
  input  logic                         reset,
  input  logic                         clr,
  input  logic                         beat_en,
  input  logic                         uncached,
  input  logic [CNT_W-1:0]             crit_idx,
  input  logic [WORD_W-1:0]            beat_data,
  output logic [CNT_W-1:0]             beat_cnt,
  output logic                         crit_hit,
  output logic [LINE_WORDS*WORD_W-1:0] line
);

  logic [LINE_WORDS-1:0][WORD_W-1:0] line_q;
  logic [LINE_WORDS-1:0]             we;
  logic [CNT_W-1:0]                  wr_idx;

  // Uncached fetches always land in word 0 regardless of the beat count.
  assign wr_idx   = uncached ? '0 : beat_cnt;
  assign we       = beat_en ? (LINE_WORDS'(1) << wr_idx) : '0;
  assign crit_hit = uncached | (beat_cnt == crit_idx);
  assign line     = line_q;

  // Beat counter: cleared at the read handshake, wraps so extra beats overwrite from word 0.
  always_ff @(posedge aclk) begin
    if (reset || clr) beat_cnt <= '0;
    else if (beat_en) beat_cnt <= beat_cnt + 1'b1;
  end

  genvar w;
  generate
    for (w = 0; w < LINE_WORDS; w++) begin : g_word
      // One 32-bit slot of the line, written only when its decode bit is set.
      always_ff @(posedge aclk) begin
        if (reset) line_q[w] <= '0;
        else if (we[w]) line_q[w] <= beat_data;
      end
    end
  endgenerate

endmodule

// File: rtl/icache_refill.sv
// Icache miss/refill engine: one outstanding miss, line or word read, critical-word forward.
module icache_refill
  import icache_refill_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                         aclk,
  input  logic                         reset,
  input  logic                         miss_req,
  input  logic                         miss_uncached,
  input  logic [ADDR_W-1:0]            miss_addr,
  output logic                         miss_ready,
  output logic                         rd_req,
  output logic [2:0]                   rd_type,
  output logic [ADDR_W-1:0]            rd_addr,
  input  logic                         rd_rdy,
  input  logic                         ret_valid,
  input  logic                         ret_last,
  input  logic [WORD_W-1:0]            ret_data,
  output logic                         fwd_valid,
  output logic [WORD_W-1:0]            fwd_data,
  output logic                         refill_valid,
  output logic [ADDR_W-1:0]            refill_addr,
  output logic [LINE_WORDS*WORD_W-1:0] refill_line,
  output logic                         protocol_err
);

  localparam int CNT_W = $clog2(LINE_WORDS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_WORDS - 1);

  state_t           state;
  logic             lat_unc;
  logic [CNT_W-1:0] lat_crit;
  logic [CNT_W-1:0] beat_cnt;
  logic             crit_hit;
  logic             beat_en;
  logic             rd_hs;

  // Beats outside RECV (including one coincident with the handshake) are dropped.
  assign beat_en = (state == ST_RECV) & ret_valid;
  assign rd_hs   = (state == ST_REQ) & rd_rdy;

  icache_line_assembler #(.LINE_WORDS(LINE_WORDS)) u_asm (
    .aclk      (aclk),
    .reset     (reset),
    .clr       (rd_hs),
    .beat_en   (beat_en),
    .uncached  (lat_unc),
    .crit_idx  (lat_crit),
    .beat_data (ret_data),
    .beat_cnt  (beat_cnt),
    .crit_hit  (crit_hit),
    .line      (refill_line)
  );

  // Control FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state        <= ST_IDLE;
      lat_unc      <= 1'b0;
      lat_crit     <= '0;
      miss_ready   <= 1'b1;
      rd_req       <= 1'b0;
      rd_type      <= '0;
      rd_addr      <= '0;
      fwd_valid    <= 1'b0;
      fwd_data     <= '0;
      refill_valid <= 1'b0;
      refill_addr  <= '0;
      protocol_err <= 1'b0;
    end else begin
      fwd_valid    <= 1'b0;
      refill_valid <= 1'b0;
      protocol_err <= 1'b0;
      if (beat_en && crit_hit) begin
        fwd_valid <= 1'b1;
        fwd_data  <= ret_data;
      end
      unique case (state)
        ST_IDLE: if (miss_req) begin
          lat_unc     <= miss_uncached;
          lat_crit    <= miss_addr[LINE_OFFSET_BITS-1:2];
          miss_ready  <= 1'b0;
          rd_req      <= 1'b1;
          rd_type     <= miss_uncached ? RD_TYPE_WORD : RD_TYPE_LINE;
          rd_addr     <= miss_uncached ? miss_addr
                                       : {miss_addr[ADDR_W-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
          refill_addr <= {miss_addr[ADDR_W-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
          state       <= ST_REQ;
        end
        ST_REQ: if (rd_rdy) begin
          rd_req <= 1'b0;
          state  <= ST_RECV;
        end
        ST_RECV: if (ret_valid) begin
          if (ret_last) begin
            refill_valid <= ~lat_unc;
            protocol_err <= ~lat_unc & (beat_cnt != LAST_IDX);
            state        <= ST_DONE;
          end else if (lat_unc || beat_cnt == LAST_IDX) begin
            protocol_err <= 1'b1;
          end
        end
        ST_DONE: begin
          miss_ready <= 1'b1;
          state      <= ST_IDLE;
        end
        default: begin
          miss_ready <= 1'b1;
          rd_req     <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill.sv
// Self-checking bench for icache_refill: directed scenarios plus randomized misses vs a line model.
module tb_icache_refill;

  logic         aclk = 1'b0;
  logic         reset = 1'b1;
  logic         miss_req = 1'b0, miss_uncached = 1'b0;
  logic [31:0]  miss_addr = '0;
  logic         miss_ready, rd_req, rd_rdy = 1'b0;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         ret_valid = 1'b0, ret_last = 1'b0;
  logic [31:0]  ret_data = '0;
  logic         fwd_valid, refill_valid, protocol_err;
  logic [31:0]  fwd_data, refill_addr;
  logic [127:0] refill_line;

  always #5 aclk = ~aclk;

  icache_refill dut (
    .aclk(aclk), .reset(reset), .miss_req(miss_req), .miss_uncached(miss_uncached),
    .miss_addr(miss_addr), .miss_ready(miss_ready), .rd_req(rd_req), .rd_type(rd_type),
    .rd_addr(rd_addr), .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_last(ret_last),
    .ret_data(ret_data), .fwd_valid(fwd_valid), .fwd_data(fwd_data),
    .refill_valid(refill_valid), .refill_addr(refill_addr), .refill_line(refill_line),
    .protocol_err(protocol_err)
  );

  int passed = 0, total = 0;
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // Monitor: records every output pulse with the cycle it was seen in.
  logic [31:0]  fwd_q[$];
  int           fwd_cyc_q[$];
  int           ref_cnt = 0, err_cnt = 0, ref_cyc = 0;
  logic [31:0]  ref_addr = '0;
  logic [127:0] ref_line = '0;
  always @(negedge aclk) begin
    if (!reset) begin
      if (fwd_valid) begin fwd_q.push_back(fwd_data); fwd_cyc_q.push_back(cyc); end
      if (refill_valid) begin ref_cnt++; ref_addr = refill_addr; ref_line = refill_line; ref_cyc = cyc; end
      if (protocol_err) err_cnt++;
    end
  end

  // Driver observations for the last transaction.
  int          txn_fwd0, txn_ref0, txn_err0, rd_unstable, mr_busy;
  logic        rd_seen, rd_after;
  logic [2:0]  obs_rd_type;
  logic [31:0] obs_rd_addr;
  int          beat_cyc[8];

  // Reference model: words persist in the line across misses until overwritten.
  logic [127:0] model_line = '0;
  logic [31:0]  exp_fwd[$];
  int           exp_fwd_b[$];
  int           exp_ref, exp_err;

  task automatic model(input logic [31:0] addr, input logic unc, input int nb, input logic [31:0] dat[8]);
    int idx = 0;
    exp_fwd.delete(); exp_fwd_b.delete(); exp_ref = 0; exp_err = 0;
    for (int b = 0; b < nb; b++) begin
      model_line[(unc ? 0 : idx)*32 +: 32] = dat[b];
      if (unc || idx == int'(addr[3:2])) begin exp_fwd.push_back(dat[b]); exp_fwd_b.push_back(b); end
      if (b == nb - 1) begin
        if (!unc && idx != 3) exp_err++;
        exp_ref = unc ? 0 : 1;
      end else if (unc || idx == 3) exp_err++;
      idx = (idx + 1) % 4;
    end
  endtask

  // Drives one miss; the final beat carries ret_last. gap[b] idle cycles precede beat b.
  task automatic run_miss(input logic [31:0] addr, input logic unc, input int rdy_wait, input int nb,
                          input int gap[8], input logic [31:0] dat[8], input logic try_new);
    int n = 0;
    model(addr, unc, nb, dat);
    txn_fwd0 = fwd_q.size(); txn_ref0 = ref_cnt; txn_err0 = err_cnt;
    rd_unstable = 0; mr_busy = 0;
    while (!miss_ready && n < 50) begin @(posedge aclk); #1; n++; end
    miss_req = 1; miss_addr = addr; miss_uncached = unc;
    @(posedge aclk); #1;
    miss_req = 0; miss_addr = $urandom; miss_uncached = 1'($urandom);
    rd_seen = rd_req; obs_rd_type = rd_type; obs_rd_addr = rd_addr;
    for (int i = 0; i < rdy_wait; i++) begin
      if (try_new) begin miss_req = 1; miss_addr = 32'h0BAD_0000; miss_uncached = 0; end
      @(posedge aclk); #1;
      if (!rd_req || rd_type !== obs_rd_type || rd_addr !== obs_rd_addr) rd_unstable++;
      if (miss_ready) mr_busy++;
    end
    miss_req = 0;
    rd_rdy = 1; @(posedge aclk); #1; rd_rdy = 0;
    rd_after = rd_req;
    for (int b = 0; b < nb; b++) begin
      for (int g = 0; g < gap[b]; g++) begin @(posedge aclk); #1; end
      ret_valid = 1; ret_data = dat[b]; ret_last = (b == nb - 1); beat_cyc[b] = cyc;
      @(posedge aclk); #1;
      ret_valid = 0; ret_last = 0; ret_data = $urandom;
    end
    repeat (3) @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(posedge aclk);
    #1;
    total++; if (miss_ready !== 1'b1) $display("FAIL reset_miss_ready got=%b want=1", miss_ready); else passed++;
    total++; if (rd_req !== 1'b0) $display("FAIL reset_rd_req got=%b want=0", rd_req); else passed++;
    total++; if (rd_type !== 3'b000 || rd_addr !== 32'h0) $display("FAIL reset_rd got=%h/%h want=0/0", rd_type, rd_addr); else passed++;
    total++; if ({fwd_valid, refill_valid, protocol_err} !== 3'b000) $display("FAIL reset_pulses got=%b want=000", {fwd_valid, refill_valid, protocol_err}); else passed++;
    total++; if (refill_line !== 128'h0 || refill_addr !== 32'h0) $display("FAIL reset_line got=%h/%h want=0", refill_line, refill_addr); else passed++;
    reset = 0; model_line = '0;
    // A stray beat in IDLE must be ignored.
    ret_valid = 1; ret_last = 1; ret_data = 32'hFFFF_FFFF;
    @(posedge aclk); #1; ret_valid = 0; ret_last = 0;
    repeat (2) @(posedge aclk);
    #1;
    total++; if (miss_ready !== 1'b1 || fwd_q.size() != 0 || err_cnt != 0 || ref_cnt != 0 || refill_line !== 128'h0)
      $display("FAIL idle_beat got ready=%b fwd=%0d err=%0d ref=%0d want 1/0/0/0", miss_ready, fwd_q.size(), err_cnt, ref_cnt); else passed++;
  endtask

  task automatic test_cached();
    int g[8] = '{default:0};
    logic [31:0] d[8] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 0, 0, 0, 0};
    run_miss(32'h1C00_0008, 0, 0, 4, g, d, 0);
    total++; if (rd_seen !== 1'b1) $display("FAIL cached_rd_req_latency got=%b want=1", rd_seen); else passed++;
    total++; if (obs_rd_type !== 3'b100) $display("FAIL cached_rd_type got=%b want=100", obs_rd_type); else passed++;
    total++; if (obs_rd_addr !== 32'h1C00_0000) $display("FAIL cached_rd_addr got=%h want=1c000000", obs_rd_addr); else passed++;
    total++; if (rd_after !== 1'b0) $display("FAIL cached_rd_drop got=%b want=0", rd_after); else passed++;
    total++; if (fwd_q.size() - txn_fwd0 != 1 || fwd_q[fwd_q.size()-1] !== 32'hA2)
      $display("FAIL cached_fwd got n=%0d want n=1 data=a2", fwd_q.size() - txn_fwd0); else passed++;
    total++; if (fwd_cyc_q[fwd_cyc_q.size()-1] != beat_cyc[2] + 1)
      $display("FAIL cached_fwd_time got=%0d want=%0d", fwd_cyc_q[fwd_cyc_q.size()-1], beat_cyc[2] + 1); else passed++;
    total++; if (ref_cnt - txn_ref0 != 1) $display("FAIL cached_refill_cnt got=%0d want=1", ref_cnt - txn_ref0); else passed++;
    total++; if (ref_line !== 128'h000000A3_000000A2_000000A1_000000A0)
      $display("FAIL cached_line got=%h want=000000a3000000a2000000a1000000a0", ref_line); else passed++;
    total++; if (ref_addr !== 32'h1C00_0000 || ref_cyc != beat_cyc[3] + 1)
      $display("FAIL cached_refill_addr_time got=%h@%0d want=1c000000@%0d", ref_addr, ref_cyc, beat_cyc[3] + 1); else passed++;
    total++; if (err_cnt != txn_err0 || miss_ready !== 1'b1)
      $display("FAIL cached_end got err=%0d ready=%b want 0/1", err_cnt - txn_err0, miss_ready); else passed++;
  endtask

  task automatic test_uncached();
    int g[8] = '{default:0};
    logic [31:0] d[8] = '{32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0};
    run_miss(32'h1FE0_0004, 1, 0, 1, g, d, 0);
    total++; if (obs_rd_type !== 3'b010 || obs_rd_addr !== 32'h1FE0_0004)
      $display("FAIL uncached_rd got=%b/%h want=010/1fe00004", obs_rd_type, obs_rd_addr); else passed++;
    total++; if (fwd_q.size() - txn_fwd0 != 1 || fwd_q[fwd_q.size()-1] !== 32'hDEAD_BEEF)
      $display("FAIL uncached_fwd got n=%0d want n=1 data=deadbeef", fwd_q.size() - txn_fwd0); else passed++;
    total++; if (ref_cnt != txn_ref0 || err_cnt != txn_err0)
      $display("FAIL uncached_no_refill got ref=%0d err=%0d want 0/0", ref_cnt - txn_ref0, err_cnt - txn_err0); else passed++;
  endtask

  task automatic test_stall();
    int g[8] = '{default:0};
    logic [31:0] d[8] = '{32'h10, 32'h11, 32'h12, 32'h13, 0, 0, 0, 0};
    run_miss(32'h1C00_0010, 0, 5, 4, g, d, 1);
    total++; if (rd_unstable != 0) $display("FAIL stall_rd_stable got=%0d unstable cycles want=0", rd_unstable); else passed++;
    total++; if (mr_busy != 0) $display("FAIL stall_miss_ready got=%0d ready cycles want=0", mr_busy); else passed++;
    total++; if (ref_cnt - txn_ref0 != 1 || ref_addr !== 32'h1C00_0010)
      $display("FAIL stall_no_second_miss got n=%0d addr=%h want 1/1c000010", ref_cnt - txn_ref0, ref_addr); else passed++;
    total++; if (fwd_q.size() - txn_fwd0 != 1 || fwd_q[fwd_q.size()-1] !== 32'h10)
      $display("FAIL stall_fwd got n=%0d want n=1 data=10", fwd_q.size() - txn_fwd0); else passed++;
  endtask

  task automatic test_gaps();
    int g[8] = '{0, 2, 0, 1, 0, 0, 0, 0};
    logic [31:0] d[8] = '{32'h11, 32'h22, 32'h33, 32'h44, 0, 0, 0, 0};
    run_miss(32'h2000_0004, 0, 0, 4, g, d, 0);
    total++; if (ref_cnt - txn_ref0 != 1) $display("FAIL gaps_refill_cnt got=%0d want=1", ref_cnt - txn_ref0); else passed++;
    total++; if (ref_line !== 128'h00000044_00000033_00000022_00000011)
      $display("FAIL gaps_line got=%h want=00000044000000330000002200000011", ref_line); else passed++;
    total++; if (fwd_q.size() - txn_fwd0 != 1 || fwd_q[fwd_q.size()-1] !== 32'h22)
      $display("FAIL gaps_fwd got n=%0d want n=1 data=22", fwd_q.size() - txn_fwd0); else passed++;
  endtask

  task automatic test_early_last();
    int g[8] = '{default:0};
    logic [31:0] d[8] = '{32'h55, 32'h66, 0, 0, 0, 0, 0, 0};
    run_miss(32'h3000_0000, 0, 0, 2, g, d, 0);
    total++; if (err_cnt - txn_err0 != 1) $display("FAIL early_err got=%0d want=1", err_cnt - txn_err0); else passed++;
    total++; if (ref_cnt - txn_ref0 != 1 || ref_line[63:0] !== 64'h00000066_00000055)
      $display("FAIL early_refill got n=%0d low=%h want 1/0000006600000055", ref_cnt - txn_ref0, ref_line[63:0]); else passed++;
    total++; if (miss_ready !== 1'b1) $display("FAIL early_idle got=%b want=1", miss_ready); else passed++;
  endtask

  task automatic test_reset_mid();
    int f0, r0, e0;
    int g[8] = '{default:0};
    logic [31:0] d[8];
    miss_req = 1; miss_addr = 32'h4000_000C; miss_uncached = 0;
    @(posedge aclk); #1; miss_req = 0;
    rd_rdy = 1; @(posedge aclk); #1; rd_rdy = 0;
    for (int b = 0; b < 2; b++) begin
      ret_valid = 1; ret_data = 32'h7700 + b;
      @(posedge aclk); #1; ret_valid = 0;
    end
    f0 = fwd_q.size(); r0 = ref_cnt; e0 = err_cnt;
    reset = 1; @(posedge aclk); #1; reset = 0; model_line = '0;
    total++; if (miss_ready !== 1'b1 || rd_req !== 1'b0 || refill_line !== 128'h0)
      $display("FAIL rstmid_idle got ready=%b rd=%b line=%h want 1/0/0", miss_ready, rd_req, refill_line); else passed++;
    for (int b = 2; b < 4; b++) begin
      ret_valid = 1; ret_last = (b == 3); ret_data = 32'h7700 + b;
      @(posedge aclk); #1; ret_valid = 0; ret_last = 0;
    end
    repeat (3) @(posedge aclk);
    #1;
    total++; if (fwd_q.size() != f0 || ref_cnt != r0 || err_cnt != e0)
      $display("FAIL rstmid_quiet got fwd=%0d ref=%0d err=%0d want 0/0/0", fwd_q.size() - f0, ref_cnt - r0, err_cnt - e0); else passed++;
    for (int i = 0; i < 8; i++) d[i] = $urandom;
    run_miss(32'h4000_0008, 0, 1, 4, g, d, 0);
    total++; if (ref_cnt - txn_ref0 != 1 || ref_line !== model_line)
      $display("FAIL rstmid_next got n=%0d line=%h want 1/%h", ref_cnt - txn_ref0, ref_line, model_line); else passed++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      int g[8];
      logic [31:0] d[8];
      logic [31:0] addr = $urandom;
      logic unc = ($urandom_range(3) == 0);
      int nb, sel, nf;
      sel = $urandom_range(5);
      nb = unc ? ((sel == 0) ? 2 : 1) : ((sel == 0) ? 2 : (sel == 1) ? 6 : 4);
      for (int i = 0; i < 8; i++) begin g[i] = $urandom_range(2); d[i] = $urandom; end
      run_miss(addr, unc, $urandom_range(3), nb, g, d, 0);
      total++; if (obs_rd_type !== (unc ? 3'b010 : 3'b100) || obs_rd_addr !== (unc ? addr : {addr[31:4], 4'h0}))
        $display("FAIL rand%0d_rd got=%b/%h addr=%h unc=%b", it, obs_rd_type, obs_rd_addr, addr, unc); else passed++;
      nf = fwd_q.size() - txn_fwd0;
      total++; if (nf != exp_fwd.size()) $display("FAIL rand%0d_fwd_cnt got=%0d want=%0d", it, nf, exp_fwd.size()); else passed++;
      for (int k = 0; k < nf && k < exp_fwd.size(); k++) begin
        total++; if (fwd_q[txn_fwd0+k] !== exp_fwd[k] || fwd_cyc_q[txn_fwd0+k] != beat_cyc[exp_fwd_b[k]] + 1)
          $display("FAIL rand%0d_fwd%0d got=%h@%0d want=%h@%0d", it, k, fwd_q[txn_fwd0+k], fwd_cyc_q[txn_fwd0+k], exp_fwd[k], beat_cyc[exp_fwd_b[k]] + 1); else passed++;
      end
      total++; if (ref_cnt - txn_ref0 != exp_ref) $display("FAIL rand%0d_ref_cnt got=%0d want=%0d", it, ref_cnt - txn_ref0, exp_ref); else passed++;
      if (exp_ref == 1) begin
        total++; if (ref_line !== model_line || ref_addr !== {addr[31:4], 4'h0} || ref_cyc != beat_cyc[nb-1] + 1)
          $display("FAIL rand%0d_refill got=%h/%h@%0d want=%h/%h@%0d", it, ref_line, ref_addr, ref_cyc, model_line, {addr[31:4], 4'h0}, beat_cyc[nb-1] + 1); else passed++;
      end
      total++; if (err_cnt - txn_err0 != exp_err) $display("FAIL rand%0d_err got=%0d want=%0d", it, err_cnt - txn_err0, exp_err); else passed++;
      total++; if (miss_ready !== 1'b1) $display("FAIL rand%0d_idle got=%b want=1", it, miss_ready); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_cached();
    test_uncached();
    test_stall();
    test_gaps();
    test_early_last();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/icache_refill.md
Name: icache_refill

Overview:
- Miss/refill engine between the instruction cache and the SRAM-AXI bridge's icache read interface.
- Accepts one miss at a time from the icache and issues one bridge read: a 4-beat line read for cached misses, a single-word read for uncached ones.
- Collects the returned beats into a 128-bit line and hands the line back to the icache.
- Forwards the critical word, i.e. the word at the original miss address, as soon as it arrives.

Parameters:
- ADDR_W, 32, address width.
- LINE_WORDS, 4, words per line. Fixed at 4 to match the bridge burst length (arlen=3); other values are unsupported.

Ports:
- aclk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- miss_req  in  1  icache miss request.
- miss_uncached  in  1  1 = single-word uncached fetch.
- miss_addr  in  32  byte address of the missing instruction.
- miss_ready  out  1  engine idle; miss accepted when miss_req & miss_ready.
- rd_req  out  1  read request to bridge.
- rd_type  out  3  3'b100 = line, 3'b010 = word.
- rd_addr  out  32  request address.
- rd_rdy  in  1  bridge accepts; handshake is rd_req & rd_rdy.
- ret_valid  in  1  return beat valid.
- ret_last  in  1  final beat.
- ret_data  in  32  beat data.
- fwd_valid  out  1  one-cycle pulse: critical word available.
- fwd_data  out  32  critical word.
- refill_valid  out  1  one-cycle pulse: line complete (cached misses only).
- refill_addr  out  32  line address, {miss_addr[31:4], 4'b0}.
- refill_line  out  128  word i in bits [32i+31:32i].
- protocol_err  out  1  one-cycle pulse on a beat-count violation.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; beat_cnt = 0.
  - All outputs 0 except miss_ready = 1.
  - refill_line is cleared to 0.
  - Reset mid-operation drops the outstanding miss. Later ret_valid beats are ignored in IDLE.
- States: IDLE, REQ, RECV, DONE (one-hot).
- IDLE:
  - miss_ready = 1.
  - On miss_req, latch the address and uncached flag, then go to REQ.
  - ret_valid in IDLE is ignored and produces no error.
- REQ:
  - rd_req = 1.
  - rd_type = uncached ? 3'b010 : 3'b100.
  - rd_addr = uncached ? miss_addr : {miss_addr[31:4], 4'b0}.
  - rd_type and rd_addr stay stable until the handshake.
  - On rd_rdy, go to RECV with beat_cnt = 0.
  - rd_req is first asserted the cycle after miss acceptance.
- RECV, on each ret_valid:
  - Store ret_data into word beat_cnt of refill_line (uncached: word 0 only).
  - Increment beat_cnt (2-bit, wraps).
  - If the beat is critical (uncached, or beat_cnt == miss_addr[3:2]), register it: fwd_valid = 1 and fwd_data = ret_data on the next cycle.
- Leaving RECV:
  - ret_valid & ret_last → DONE.
  - Cached: ret_last on beat_cnt != 3 → protocol_err pulse; still go to DONE.
  - Cached: beat_cnt == 3 without ret_last → protocol_err pulse; stay in RECV, and later beats overwrite from word 0.
  - Uncached: a beat without ret_last → protocol_err pulse; stay in RECV.
- DONE:
  - Cached: refill_valid = 1 for exactly one cycle with the assembled line and refill_addr.
  - Uncached: no refill_valid.
  - Next state is IDLE. miss_ready goes high the cycle after DONE.
- Latency, cached miss with zero-wait bridge:
  - Accept at cycle 0; rd handshake at cycle 1.
  - Beats arrive no earlier than cycle 2.
  - refill_valid is one cycle after the last beat.
- Simultaneous events:
  - A beat in the same cycle as the rd handshake is impossible by state; ignore it.
  - If fwd_valid and refill_valid coincide (critical word is beat 3), both assert.
- No back-pressure to the bridge: the engine is always ready in RECV.

Decomposition:
- Shared package holds:
  - RD_TYPE_WORD = 3'b010, RD_TYPE_LINE = 3'b100.
  - LINE_OFFSET_BITS = 4.
  - State one-hot encodings.
- One natural sub-module: icache_line_assembler, containing the beat counter, the word write-enable decode, the 128-bit line register and critical-word match. The FSM stays in the top module.

Test Plan:
- Cached miss at 0x1C000008, bridge returns 0xA0, 0xA1, 0xA2, 0xA3 (last on beat 3) → rd_type = 3'b100, rd_addr = 0x1C000000; fwd_valid with 0xA2 one cycle after beat 2; refill_valid with line {0xA3, 0xA2, 0xA1, 0xA0} and refill_addr 0x1C000000.
- Uncached miss at 0x1FE00004, one beat 0xDEADBEEF with ret_last → rd_type = 3'b010, rd_addr = 0x1FE00004; fwd_valid with 0xDEADBEEF; no refill_valid.
- rd_rdy held low for 5 cycles → rd_req, rd_addr and rd_type stable all 5 cycles; miss_ready = 0; a new miss_req is not accepted.
- Gaps between beats (ret_valid 1, 0, 0, 1, 1, 0, 1) → line is assembled correctly and refill_valid fires exactly once.
- Cached miss with ret_last on beat 1 → protocol_err pulse, refill_valid pulse, return to IDLE.
- Reset asserted for one cycle during RECV after 2 beats → IDLE, miss_ready = 1; the remaining beats produce no fwd/refill/err; the next miss completes normally.
